// File: rtl/instr_fetch_buffer.sv
// IF-stage instruction memory with a loadable synchronous RAM, a fetch-PC generator and a
// prefetch FIFO that streams {ir, ir_pc} to decode over a valid/ready handshake.
module instr_fetch_buffer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              ir_ready,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [31:0]       ir_pc,
  output logic              ir_fault
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              inflight_q;
  logic [31:0]       inflight_pc_q;
  logic              inflight_fault_q;

  logic [DATA_W-1:0] fifo_ir_q    [FIFO_DEPTH];
  logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
  logic              fifo_fault_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic              fetch_in_range;
  logic              load_in_range;
  logic [CntW:0]     occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_ir;

  assign fetch_in_range = fetch_pc_q < 32'(DEPTH);
  assign load_in_range  = 32'(load_addr) < 32'(DEPTH);

  // Pre-pop count plus the in-flight read, so a slot is guaranteed for every issued read.
  assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q);
  assign issue     = (occupancy < (CntW + 1)'(FIFO_DEPTH)) && !load_we && !redirect_valid;

  assign push    = inflight_q && !redirect_valid;
  assign pop     = (count_q != '0) && ir_ready && !redirect_valid;
  assign push_ir = inflight_fault_q ? '0 : rdata_q;

  // RAM array and its read register carry no reset.
  always_ff @(posedge clk) begin
    if (load_we && load_in_range) begin
      mem[load_addr] <= load_data;
    end
    if (issue && fetch_in_range) begin
      rdata_q <= mem[fetch_pc_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir_q[wr_ptr_q]    <= push_ir;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_fault_q[wr_ptr_q] <= inflight_fault_q;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_fault_q <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q    <= fetch_pc_q;
        inflight_fault_q <= !fetch_in_range;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ir_valid = 1'b0;
    ir       = '0;
    ir_pc    = '0;
    ir_fault = 1'b0;
    if (count_q != '0) begin
      ir_valid = 1'b1;
      ir       = fifo_ir_q[rd_ptr_q];
      ir_pc    = fifo_pc_q[rd_ptr_q];
      ir_fault = fifo_fault_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: streaming, stall, redirect, range fault, async reset
// and program-load ordering.
module tb_instr_fetch_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;

  localparam logic [31:0] Base   = 32'hC0DE_0000;
  localparam logic [31:0] W100   = 32'h1111_0100;
  localparam logic [31:0] W101   = 32'h1111_0101;
  localparam logic [31:0] WLast  = 32'h2222_03FF;
  localparam logic [31:0] New5   = 32'h5555_AAAA;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_we = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = '0;
  logic              ir_ready = 1'b0;
  logic              ir_valid;
  logic [DATA_W-1:0] ir;
  logic [31:0]       ir_pc;
  logic              ir_fault;

  int n_tests = 0;
  int n_fail  = 0;
  logic [65:0] got, exp;

  instr_fetch_buffer #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .FIFO_DEPTH(4),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ir_ready      (ir_ready),
    .ir_valid      (ir_valid),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_fault      (ir_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] mk(input logic v, input logic f, input logic [31:0] pc,
                                     input logic [31:0] w);
    return {v, f, pc, w};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_we   = 1'b0;
  endtask

  // Reset-state outputs, then program load while reset is held.
  task automatic test_reset();
    #2;
    got = {ir_valid, ir_fault, ir_pc, ir};
    exp = mk(1'b0, 1'b0, 32'd0, 32'd0);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=%h", got, exp);
    end
    step();
    for (int i = 0; i < 10; i++) load_word(ADDR_W'(i), Base + 32'(i));
    load_word(ADDR_W'(100), W100);
    load_word(ADDR_W'(101), W101);
    load_word(ADDR_W'(DEPTH - 1), WLast);
  endtask

  // Release reset with redirect to 0: first valid two cycles after the redirect edge.
  task automatic test_stream();
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    ir_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 2) exp = mk(1'b0, 1'b0, 32'd0, 32'd0);
      else exp = mk(1'b1, 1'b0, 32'(c - 2), Base + 32'(c - 2));
      got = {ir_valid, ir_fault, ir_pc, ir};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stream cyc%0d got=%h want=%h", c, got, exp);
      end
      if (c < 5) step();
    end
  endtask

  // Stall 10 cycles: head stays at PC 3; release continues 4..9 without a gap.
  task automatic test_stall();
    ir_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      got = {ir_valid, ir_fault, ir_pc, ir};
      exp = mk(1'b1, 1'b0, 32'd3, Base + 32'd3);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d got=%h want=%h", c, got, exp);
      end
    end
    ir_ready = 1'b1;
    for (int p = 4; p < 10; p++) begin
      step();
      got = {ir_valid, ir_fault, ir_pc, ir};
      exp = mk(1'b1, 1'b0, 32'(p), Base + 32'(p));
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall_release pc%0d got=%h want=%h", p, got, exp);
      end
    end
  endtask

  // Redirect (with a simultaneous pop) while full; expect two empty cycles, then 100, 101.
  task automatic test_redirect();
    ir_ready = 1'b0;
    for (int c = 0; c < 6; c++) step();
    ir_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd100;
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) exp = mk(1'b0, 1'b0, 32'd0, 32'd0);
      else if (c == 2) exp = mk(1'b1, 1'b0, 32'd100, W100);
      else exp = mk(1'b1, 1'b0, 32'd101, W101);
      got = {ir_valid, ir_fault, ir_pc, ir};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL redirect cyc%0d got=%h want=%h", c, got, exp);
      end
      if (c < 3) step();
    end
  endtask

  // Last valid word, then out-of-range PCs come back as faulting NOPs.
  task automatic test_range_fault();
    redirect_valid = 1'b1;
    redirect_pc    = 32'(DEPTH - 1);
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) exp = mk(1'b0, 1'b0, 32'd0, 32'd0);
      else if (c == 2) exp = mk(1'b1, 1'b0, 32'(DEPTH - 1), WLast);
      else exp = mk(1'b1, 1'b1, 32'(DEPTH + c - 3), 32'd0);
      got = {ir_valid, ir_fault, ir_pc, ir};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL range_fault cyc%0d got=%h want=%h", c, got, exp);
      end
      if (c < 4) step();
    end
  endtask

  // Mid-cycle reset clears outputs without a clock edge; refetch starts at PC 0.
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    got = {ir_valid, ir_fault, ir_pc, ir};
    exp = mk(1'b0, 1'b0, 32'd0, 32'd0);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=%h", got, exp);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) exp = mk(1'b0, 1'b0, 32'd0, 32'd0);
      else exp = mk(1'b1, 1'b0, 32'(c - 1), Base + 32'(c - 1));
      got = {ir_valid, ir_fault, ir_pc, ir};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_refetch cyc%0d got=%h want=%h", c, got, exp);
      end
    end
  endtask

  // Load to 5 while PC 5 is in flight: old word first, new word after a redirect.
  task automatic test_load_inflight();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd5;
    step();
    redirect_valid = 1'b0;
    step();
    load_word(ADDR_W'(5), New5);
    got = {ir_valid, ir_fault, ir_pc, ir};
    exp = mk(1'b1, 1'b0, 32'd5, Base + 32'd5);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL load_old_word got=%h want=%h", got, exp);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'd5;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    got = {ir_valid, ir_fault, ir_pc, ir};
    exp = mk(1'b1, 1'b0, 32'd5, New5);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL load_new_word got=%h want=%h", got, exp);
    end
    step();
    got = {ir_valid, ir_fault, ir_pc, ir};
    exp = mk(1'b1, 1'b0, 32'd6, Base + 32'd6);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL load_next_word got=%h want=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_range_fault();
    test_async_reset();
    test_load_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
